// File: rtl/legv8_pkg.sv
// legv8_pkg: shared types and constants for the LEGv8 core front end.
//
// Contents:
//   WORD          datapath / address width. It mirrors the core-wide WORD
//                 width so that the fetch stage does not need to include the
//                 header itself.
//   INSTR_W       instruction word width (32).
//   PC_STEP       sequential PC increment in bytes (4).
//   fetch_state_t fetch FSM state encoding. S_FAULT exists only when
//                 FETCH_ALIGN_CHECK_EN is defined.
//
// Configuration macro: FETCH_ALIGN_CHECK_EN
package legv8_pkg;

  localparam int WORD    = 64;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
`ifdef FETCH_ALIGN_CHECK_EN
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
`else
    S_HOLD  = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC selection for the fetch stage.
//
// Ports:
//   pc_i            current PC
//   branch_taken_i  Execute redirect decision for the presented instruction
//   branch_target_i absolute branch target from Execute
//   next_pc_o       PC to load on acceptance
//   misaligned_o    taken branch to a non-word-aligned target
//                   (present only with FETCH_ALIGN_CHECK_EN)
//
// Configuration macro: FETCH_ALIGN_CHECK_EN
//   defined     - target loads unchanged, misalignment is flagged
//   not defined - target loads with bits [1:0] forced to zero
module pc_next
  import legv8_pkg::*;
(
  input  logic [WORD-1:0] pc_i,
  input  logic            branch_taken_i,
  input  logic [WORD-1:0] branch_target_i,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic            misaligned_o,
`endif
  output logic [WORD-1:0] next_pc_o
);

  // The sequential increment wraps modulo 2^WORD by construction.
  always_comb begin
    next_pc_o = pc_i + WORD'(PC_STEP);
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned_o = 1'b0;
`endif
    if (branch_taken_i) begin
`ifdef FETCH_ALIGN_CHECK_EN
      next_pc_o    = branch_target_i;
      misaligned_o = (branch_target_i[1:0] != 2'b00);
`else
      next_pc_o    = {branch_target_i[WORD-1:2], 2'b00};
`endif
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the non-pipelined LEGv8 core.
//
// Holds the PC, reads one instruction at a time from instruction memory and
// presents it with its PC to Decode/Execute. On acceptance the PC advances
// by 4 or redirects to the branch target chosen by Execute.
//
// Parameters:
//   RESET_PC        PC loaded on reset (word aligned)
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall           downstream not ready; holds the presented instruction
//   branch_taken    redirect decision for the presented instruction
//   branch_target   absolute branch target
//   imem_req        instruction-memory read request
//   imem_addr       read address (always equals pc)
//   imem_ready      memory returns imem_data this cycle
//   imem_data       instruction word from memory
//   instr_valid     instr/pc valid for downstream
//   instr           registered instruction
//   pc              address of instr / current fetch address
//   fault           misaligned-target fault (FETCH_ALIGN_CHECK_EN only)
//   dbg_state       current FSM state (fetch_state_t encoding)
//
// Handshakes:
//   memory side:     a read completes on a rising edge where imem_req=1 and
//                    imem_ready=1; imem_req/imem_addr stay stable until then.
//                    imem_ready while imem_req=0 has no effect.
//   downstream side: an instruction is consumed on a rising edge where
//                    instr_valid=1 and stall=0; instr/pc stay stable until then.
//                    branch_taken/branch_target matter only on that edge.
//
// Configuration macro: FETCH_ALIGN_CHECK_EN (adds fault port and S_FAULT).
module fetch_unit
  import legv8_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [WORD-1:0]    branch_target,
  output logic               imem_req,
  output logic [WORD-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [WORD-1:0]    pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic               fault,
`endif
  output logic [1:0]         dbg_state
);

  fetch_state_t       state_q;
  logic [WORD-1:0]    pc_q;
  logic [WORD-1:0]    pc_d;
  logic [INSTR_W-1:0] instr_q;
  logic               imem_req_q;
  logic               instr_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               fault_q;
  logic               misaligned;
`endif

  pc_next u_pc_next (
    .pc_i            (pc_q),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
`ifdef FETCH_ALIGN_CHECK_EN
    .misaligned_o    (misaligned),
`endif
    .next_pc_o       (pc_d)
  );

  // Output flags are registered alongside the state so they never depend
  // combinationally on any input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q    <= S_REQ;
          imem_req_q <= 1'b1;
        end
        S_REQ: begin
          if (imem_ready) begin
            instr_q       <= imem_data;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (misaligned) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q    <= S_REQ;
              imem_req_q <= 1'b1;
            end
`else
            state_q    <= S_REQ;
            imem_req_q <= 1'b1;
`endif
          end
        end
`ifdef FETCH_ALIGN_CHECK_EN
        // Sticky until reset: no further requests, nothing presented.
        S_FAULT: begin
          state_q <= S_FAULT;
        end
`endif
        default: begin
          state_q       <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign dbg_state   = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign fault       = fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit (RESET_PC = 200).
// Builds against either configuration of FETCH_ALIGN_CHECK_EN.
module tb_fetch_unit;
  import legv8_pkg::*;

  localparam logic [WORD-1:0] RST_PC = 64'd200;

  logic               clk = 1'b0;
  logic               reset;
  logic               stall;
  logic               branch_taken;
  logic [WORD-1:0]    branch_target;
  logic               imem_req;
  logic [WORD-1:0]    imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_data;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [WORD-1:0]    pc;
  logic [1:0]         dbg_state;
`ifdef FETCH_ALIGN_CHECK_EN
  logic               fault;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // Scoreboard entries are {pc, instr}.
  logic [95:0] exp_q[$];

  // Reference state kept by the bench.
  logic [WORD-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc            (pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fault         (fault),
`endif
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Watchdog: every wait below is a fixed number of cycles, this only guards
  // against a simulator-level stall.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WORD-1:0] model_next(input logic [WORD-1:0] p,
                                                 input logic tk,
                                                 input logic [WORD-1:0] tgt);
    if (!tk) return p + 64'd4;
`ifdef FETCH_ALIGN_CHECK_EN
    return tgt;
`else
    return {tgt[WORD-1:2], 2'b00};
`endif
  endfunction

  // ---------------- driver tasks ----------------
  // Entry: DUT in S_REQ. Memory answers after 'lat' request cycles.
  task automatic fetch_one(input logic [INSTR_W-1:0] data, input int lat);
    logic [95:0] e;
    exp_q.push_back({m_pc, data});
    for (int i = 1; i < lat; i++) begin
      imem_ready = 1'b0;
      imem_data  = $urandom;
      check_eq("req_wait", imem_req, 1);
      check_eq("addr_wait", imem_addr, m_pc);
      check_eq("instr_wait", instr, m_instr);
      check_eq("valid_wait", instr_valid, 0);
      tick();
    end
    check_eq("req", imem_req, 1);
    check_eq("addr", imem_addr, m_pc);
    imem_ready = 1'b1;
    imem_data  = data;
    tick();
    imem_ready = 1'b0;
    imem_data  = $urandom;
    m_instr    = data;
    check_eq("valid", instr_valid, 1);
    check_eq("req_drop", imem_req, 0);
    check_eq("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("instr", instr, e[31:0]);
      check_eq("pc", pc, e[95:32]);
    end
  endtask

  // Entry: DUT in S_HOLD. Stalls for stall_n cycles with junk branch inputs,
  // then accepts with the given decision.
  task automatic accept(input logic tk, input logic [WORD-1:0] tgt, input int stall_n);
    for (int i = 0; i < stall_n; i++) begin
      stall         = 1'b1;
      branch_taken  = i[0];
      branch_target = {$urandom, $urandom};
      tick();
      check_eq("stall_valid", instr_valid, 1);
      check_eq("stall_pc", pc, m_pc);
      check_eq("stall_instr", instr, m_instr);
      check_eq("stall_req", imem_req, 0);
    end
    stall         = 1'b0;
    branch_taken  = tk;
    branch_target = tgt;
    tick();
    m_pc          = model_next(m_pc, tk, tgt);
    branch_taken  = $urandom_range(0, 1);
    branch_target = {$urandom, $urandom};
    check_eq("acc_pc", pc, m_pc);
    check_eq("acc_valid", instr_valid, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req"}, imem_req, 0);
    check_eq({tag, "_valid"}, instr_valid, 0);
    check_eq({tag, "_instr"}, instr, 0);
    check_eq({tag, "_pc"}, pc, RST_PC);
    check_eq({tag, "_addr"}, imem_addr, RST_PC);
    check_eq({tag, "_state"}, dbg_state, S_IDLE);
`ifdef FETCH_ALIGN_CHECK_EN
    check_eq({tag, "_fault"}, fault, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WORD-1:0] tgt;
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ready    = 1'b1;
    imem_data     = 32'hF84103E0;
    m_pc          = RST_PC;
    m_instr       = '0;

    // Reset with imem_ready tied high: IDLE must ignore it.
    tick();
    tick();
    check_reset_values("rst");
    reset = 1'b0;
    tick();
    check_eq("first_req", imem_req, 1);
    check_eq("first_state", dbg_state, S_REQ);

    fetch_one(32'hF84103E0, 1);          // pc 200, same-cycle ready
    accept(1'b0, '0, 0);                 // -> 204
    fetch_one(32'h8B020020, 3);          // 3-cycle memory latency
    accept(1'b0, '0, 0);                 // -> 208
    fetch_one(32'hB4000041, 1);
    accept(1'b0, '0, 4);                 // stall 4, release untaken -> 212
    fetch_one(32'hCB030041, 2);
    accept(1'b0, '0, 0);                 // -> 216
    fetch_one(32'h17FFFFF0, 1);
    accept(1'b1, 64'd196, 1);            // taken -> 196
    fetch_one(32'h14000020, 1);
    accept(1'b1, 64'd484, 0);            // taken -> 484
    fetch_one(32'hD503201F, 2);
    accept(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
    fetch_one(32'h91000421, 1);
    accept(1'b0, '0, 0);                 // wrap -> 0
    fetch_one(32'hAA0103E2, 1);

    // Misaligned target 230.
`ifdef FETCH_ALIGN_CHECK_EN
    accept(1'b1, 64'd230, 0);            // pc loads 230 unchanged
    for (int i = 0; i < 5; i++) begin
      imem_ready = i[0];
      stall      = ~i[0];
      check_eq("fault", fault, 1);
      check_eq("fault_req", imem_req, 0);
      check_eq("fault_valid", instr_valid, 0);
      check_eq("fault_state", dbg_state, S_FAULT);
      tick();
    end
    stall      = 1'b0;
    imem_ready = 1'b0;
    reset      = 1'b1;
    tick();
    check_reset_values("fault_rst");
    reset = 1'b0;
    tick();
    m_pc    = RST_PC;
    m_instr = '0;
`else
    accept(1'b1, 64'd230, 0);            // masked -> 228
    fetch_one(32'hF9400020, 1);
    accept(1'b0, '0, 0);                 // -> 232, now in S_REQ
`endif

    // Reset while a request is outstanding, late ready during IDLE.
    check_eq("pre_rst_req", imem_req, 1);
    check_eq("pre_rst_state", dbg_state, S_REQ);
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_data  = 32'hDEADBEEF;
    tick();
    check_reset_values("mid_rst");
    reset = 1'b0;
    tick();
    check_eq("post_rst_req", imem_req, 1);
    check_eq("post_rst_valid", instr_valid, 0);
    check_eq("post_rst_instr", instr, 0);
    m_pc    = RST_PC;
    m_instr = '0;

    // Randomised traffic with aligned targets.
    for (int n = 0; n < 24; n++) begin
      fetch_one($urandom, $urandom_range(1, 3));
      tgt = {$urandom, $urandom};
      tgt[1:0] = 2'b00;
      accept(1'(($urandom_range(0, 1))), tgt, $urandom_range(0, 2));
    end

    check_eq("sb_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
